// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter for the shared 256-bit data memory port.
// Requester 0 is the dcache controller, requester 1 a second cache or DMA.
// A whole transaction (enable held until ack) is granted at a time. Round-robin
// fairness applies between the two requesters. The memory bus is held idle for
// GAP_CYCLES cycles after every completed grant.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   mX_enable_i/write_i     request and direction (1=write line), held until ack
//   mX_addr_i/data_i        line address and write data
//   mX_ack_o                1-cycle done pulse to the granted requester
//   m_data_o                read data, mem_data_i broadcast to both requesters
//   mem_*_o / mem_*_i       memory port (mem_ack_i is a 1-cycle pulse)
//   grant_o                 00 none, 01 requester 0, 10 requester 1
//
// Build option: define ARB_FIXED_PRIORITY_EN to make requester 0 always win
// simultaneous requests. There is no rr pointer in that build, so requester 1
// can starve.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 256,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       pick1;   // arbitration result in IDLE: 1 selects requester 1
  logic       busy;
  logic       sel1;

`ifdef ARB_FIXED_PRIORITY_EN
  assign pick1 = m1_enable_i & ~m0_enable_i;
`else
  // rr_q=1 favours requester 1 when both requesters ask at once.
  logic rr_q, rr_d;
  assign pick1 = m1_enable_i & (~m0_enable_i | rr_q);
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gap_cnt_d = gap_cnt_q;
`ifndef ARB_FIXED_PRIORITY_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_enable_i || m1_enable_i) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // The grant is held until the memory acks, even if the enable drops.
        if (mem_ack_i) begin
          grant_d   = 2'b00;
          gap_cnt_d = '0;
`ifndef ARB_FIXED_PRIORITY_EN
          rr_d      = grant_q[0];  // favour the requester that was not just served
`endif
          state_d   = (GAP_CYCLES != 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 4'd1;
        if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      gap_cnt_q <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gap_cnt_q <= gap_cnt_d;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_q      <= rr_d;
`endif
    end
  end

  // The memory port is driven combinationally from the granted requester.
  assign busy         = (state_q == BUSY);
  assign sel1         = grant_q[1];
  assign mem_enable_o = busy;
  assign mem_write_o  = busy & (sel1 ? m1_write_i : m0_write_i);
  assign mem_addr_o   = busy ? (sel1 ? m1_addr_i : m0_addr_i) : '0;
  assign mem_data_o   = busy ? (sel1 ? m1_data_i : m0_data_i) : '0;
  assign grant_o      = grant_q;

  // Acks seen outside BUSY are dropped.
  assign m0_ack_o = busy & mem_ack_i & grant_q[0];
  assign m1_ack_o = busy & mem_ack_i & grant_q[1];
  assign m_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. The reference model tracks, at transaction level,
// which requester owns the bus, how many idle gap cycles remain, and which
// requester is favoured next. Each cycle it predicts the memory port.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 256;
  localparam int GAP = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b1;
  logic          en [2];
  logic          wr [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdat [2];
  logic          m0_ack_o, m1_ack_o;
  logic [DW-1:0] m_data_o, mem_data_o, mem_data_i;
  logic          mem_enable_o, mem_write_o, mem_ack_i;
  logic [AW-1:0] mem_addr_o;
  logic [1:0]    grant_o;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_enable_i(en[0]), .m0_write_i(wr[0]), .m0_addr_i(addr[0]), .m0_data_i(wdat[0]),
    .m0_ack_o(m0_ack_o),
    .m1_enable_i(en[1]), .m1_write_i(wr[1]), .m1_addr_i(addr[1]), .m1_data_i(wdat[1]),
    .m1_ack_o(m1_ack_o),
    .m_data_o(m_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .grant_o(grant_o)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: owner -1 means nobody holds the bus.
  int owner, gap_left, favour;
  logic          exp_en, exp_wr, exp_ack0, exp_ack1;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [1:0]    exp_grant;

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    owner = -1; gap_left = 0; favour = 0;
  endtask

  // Settle after the inputs are driven, then predict this cycle's outputs.
  task automatic eval();
    int o;
    #1;
    o         = (owner < 0) ? 0 : owner;
    exp_en    = (owner >= 0);
    exp_wr    = exp_en & wr[o];
    exp_addr  = exp_en ? addr[o] : '0;
    exp_data  = exp_en ? wdat[o] : '0;
    exp_grant = !exp_en ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10);
    exp_ack0  = exp_en && owner == 0 && mem_ack_i;
    exp_ack1  = exp_en && owner == 1 && mem_ack_i;
  endtask

  // Apply this cycle's clock edge to the model, then move to the next negedge.
  task automatic advance();
    if (owner >= 0) begin
      if (mem_ack_i) begin
        favour   = 1 - owner;
        owner    = -1;
        gap_left = GAP;
      end
    end else if (gap_left > 0) begin
      gap_left--;
    end else if (en[0] && en[1]) begin
`ifdef ARB_FIXED_PRIORITY_EN
      owner = 0;
`else
      owner = favour;
`endif
    end else if (en[0]) begin
      owner = 0;
    end else if (en[1]) begin
      owner = 1;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdat[k] = '0;
    end
    mem_ack_i  = 1'b0;
    mem_data_i = rnd_line();
    model_reset();
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdat[k] = '0;
    end
    mem_ack_i  = 1'b0;
    mem_data_i = rnd_line();
    #1 rst_i = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({mem_enable_o, mem_write_o, m0_ack_o, m1_ack_o, grant_o} !== 6'b0 ||
        mem_addr_o !== '0 || mem_data_o !== '0)
      $display("FAIL reset_outputs: en/wr/a0/a1/gnt=%b%b%b%b%b addr=%h, need all zero",
               mem_enable_o, mem_write_o, m0_ack_o, m1_ack_o, grant_o, mem_addr_o);
    else passes++;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic test_single_read();
    logic [DW-1:0] line;
    apply_reset();
    en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0000_0400; wdat[0] = rnd_line();
    eval();
    checks++;
    if (mem_enable_o !== 1'b0) $display("FAIL read_latency0: mem_enable_o=%b need 0", mem_enable_o);
    else passes++;
    advance();
    line = rnd_line();
    for (int i = 1; i <= 10; i++) begin
      mem_ack_i  = (i == 10);
      mem_data_i = (i == 10) ? line : rnd_line();
      eval();
      if (i == 1) begin
        checks++;
        if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h400 || mem_write_o !== 1'b0 || grant_o !== 2'b01)
          $display("FAIL read_start: en=%b addr=%h wr=%b gnt=%b need 1/00000400/0/01",
                   mem_enable_o, mem_addr_o, mem_write_o, grant_o);
        else passes++;
      end
      if (i == 10) begin
        checks++;
        if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || m_data_o !== line)
          $display("FAIL read_ack: ack0=%b ack1=%b data_ok=%b need 1/0/1",
                   m0_ack_o, m1_ack_o, m_data_o === line);
        else passes++;
      end
      advance();
    end
    mem_ack_i = 1'b0; en[0] = 1'b0;
    eval();
    checks++;
    if (mem_enable_o !== 1'b0 || grant_o !== 2'b00 || mem_addr_o !== '0)
      $display("FAIL read_gap: en=%b gnt=%b addr=%h need 0/00/0", mem_enable_o, grant_o, mem_addr_o);
    else passes++;
    advance();
  endtask

  task automatic test_both_same_cycle();
    apply_reset();
    en[0] = 1'b1; wr[0] = 1'b0; addr[0] = $urandom; wdat[0] = rnd_line();
    en[1] = 1'b1; wr[1] = 1'b1; addr[1] = $urandom; wdat[1] = rnd_line();
    eval(); advance();
    mem_ack_i = 1'b1;
    eval();
    checks++;
    if (grant_o !== 2'b01 || mem_addr_o !== addr[0] || m0_ack_o !== 1'b1)
      $display("FAIL both_first: gnt=%b addr=%h ack0=%b need 01/%h/1", grant_o, mem_addr_o, m0_ack_o, addr[0]);
    else passes++;
    advance();
    mem_ack_i = 1'b0; en[0] = 1'b0;
    eval(); advance();   // gap cycle
    eval(); advance();   // idle, arbitration
    eval();
    checks++;
    if (grant_o !== 2'b10 || mem_addr_o !== addr[1] || mem_write_o !== 1'b1 || mem_data_o !== wdat[1])
      $display("FAIL both_second: gnt=%b addr=%h wr=%b need 10/%h/1", grant_o, mem_addr_o, mem_write_o, addr[1]);
    else passes++;
    mem_ack_i = 1'b1;
    advance();
    mem_ack_i = 1'b0; en[1] = 1'b0;
    repeat (3) begin eval(); advance(); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]    gq [$];
    logic          wq [$];
    logic [AW-1:0] aq [$];
    logic [1:0]    prev;
    int            lat;
    logic          was;
    apply_reset();
    prev = 2'b00; lat = 0;
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h1234_5000; wdat[0] = rnd_line();
    en[1] = 1'b1; wr[1] = 1'b0; addr[1] = $urandom;      wdat[1] = rnd_line();
    for (int c = 0; c < 60 && (en[0] || en[1] || owner >= 0); c++) begin
      mem_ack_i  = (owner >= 0 && lat == 0);
      mem_data_i = rnd_line();
      eval();
      if (grant_o != 2'b00 && prev == 2'b00) begin
        gq.push_back(grant_o); wq.push_back(mem_write_o); aq.push_back(mem_addr_o);
      end
      prev = grant_o;
      was  = (owner >= 0);
      advance();
      if (!was && owner >= 0) lat = 2;
      else if (owner >= 0) lat--;
      if (exp_ack0) begin
        if (wr[0]) wr[0] = 1'b0;   // writeback done, refill the same line
        else       en[0] = 1'b0;
      end
      if (exp_ack1) en[1] = 1'b0;
    end
    mem_ack_i = 1'b0;
    checks++;
    if (gq.size() != 3)
      $display("FAIL b2b_count: grants=%0d need 3", gq.size());
    else if ({gq[0], gq[1], gq[2]} !== 6'b01_10_01 || wq[0] !== 1'b1 || wq[2] !== 1'b0 ||
             aq[0] !== 32'h1234_5000 || aq[1] !== addr[1])
      $display("FAIL b2b_order: gnt=%b,%b,%b wr0=%b wr2=%b addr0=%h need 01,10,01 1 0 12345000",
               gq[0], gq[1], gq[2], wq[0], wq[2], aq[0]);
    else passes++;
  endtask

  task automatic test_spurious_ack();
    logic bad;
    bad = 1'b0;
    mem_ack_i = 1'b1;
    repeat (3) begin
      eval();
      if (m0_ack_o || m1_ack_o || mem_enable_o || grant_o != 2'b00) bad = 1'b1;
      advance();
    end
    checks++;
    if (bad) $display("FAIL spurious_ack: ack or enable seen in IDLE (ack0=%b ack1=%b en=%b)",
                      m0_ack_o, m1_ack_o, mem_enable_o);
    else passes++;
    mem_ack_i = 1'b0;
    en[0] = 1'b1; addr[0] = $urandom;
    eval(); advance();
    eval();
    checks++;
    if (grant_o !== 2'b01 || mem_enable_o !== 1'b1)
      $display("FAIL spurious_then_req: gnt=%b en=%b need 01/1", grant_o, mem_enable_o);
    else passes++;
    mem_ack_i = 1'b1;
    advance();
    mem_ack_i = 1'b0; en[0] = 1'b0;
    repeat (2) begin eval(); advance(); end
  endtask

  task automatic test_reset_mid_busy();
    logic bad;
    apply_reset();
    en[1] = 1'b1; wr[1] = 1'b1; addr[1] = $urandom; wdat[1] = rnd_line();
    eval(); advance();
    eval();
    checks++;
    if (grant_o !== 2'b10) $display("FAIL midrst_pre: gnt=%b need 10", grant_o);
    else passes++;
    #1 rst_i = 1'b0;
    #1;
    checks++;
    if ({mem_enable_o, mem_write_o, m0_ack_o, m1_ack_o, grant_o} !== 6'b0 ||
        mem_addr_o !== '0 || mem_data_o !== '0)
      $display("FAIL midrst_outputs: en/wr/a0/a1/gnt=%b%b%b%b%b addr=%h need all zero",
               mem_enable_o, mem_write_o, m0_ack_o, m1_ack_o, grant_o, mem_addr_o);
    else passes++;
    en[1] = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      eval();
      if (mem_enable_o !== 1'b0 || grant_o !== 2'b00) bad = 1'b1;
      advance();
    end
    checks++;
    if (bad) $display("FAIL midrst_after: memory re-enabled without request (en=%b gnt=%b)",
                      mem_enable_o, grant_o);
    else passes++;
  endtask

  task automatic test_random();
    int   lat;
    logic was, a0, a1;
    apply_reset();
    lat = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++)
        if (!en[k] && $urandom_range(3) == 0) begin
          en[k] = 1'b1; wr[k] = $urandom; addr[k] = $urandom; wdat[k] = rnd_line();
        end
      mem_ack_i  = (owner >= 0) ? (lat == 0) : ($urandom_range(7) == 0);
      mem_data_i = rnd_line();
      eval();
      checks++;
      if ({mem_enable_o, mem_write_o, m0_ack_o, m1_ack_o, grant_o} !==
          {exp_en, exp_wr, exp_ack0, exp_ack1, exp_grant} ||
          mem_addr_o !== exp_addr || mem_data_o !== exp_data || m_data_o !== mem_data_i)
        $display("FAIL random cyc %0d: en/wr/a0/a1/gnt=%b%b%b%b%b addr=%h need %b%b%b%b%b addr=%h data_ok=%b",
                 c, mem_enable_o, mem_write_o, m0_ack_o, m1_ack_o, grant_o, mem_addr_o,
                 exp_en, exp_wr, exp_ack0, exp_ack1, exp_grant, exp_addr,
                 (mem_data_o === exp_data) && (m_data_o === mem_data_i));
      else passes++;
      a0 = exp_ack0; a1 = exp_ack1;
      was = (owner >= 0);
      advance();
      if (!was && owner >= 0) lat = $urandom_range(4);
      else if (owner >= 0) lat--;
      for (int k = 0; k < 2; k++) begin
        if ((k == 0 && a0) || (k == 1 && a1)) begin
          if ($urandom_range(1) == 0) begin   // back-to-back: new transaction, enable held
            wr[k] = $urandom; addr[k] = $urandom; wdat[k] = rnd_line();
          end else en[k] = 1'b0;
        end else if (owner == k && $urandom_range(15) == 0) begin
          en[k] = 1'b0;                       // enable dropped mid-transaction
        end
      end
    end
    mem_ack_i = 1'b0;
  endtask

`ifdef ARB_FIXED_PRIORITY_EN
  task automatic test_fixed_priority();
    int   lat, m0_grants;
    logic bad, was;
    apply_reset();
    bad = 1'b0; lat = 0; m0_grants = 0;
    en[0] = 1'b1; addr[0] = $urandom; en[1] = 1'b1; addr[1] = $urandom;
    for (int c = 0; c < 60; c++) begin
      mem_ack_i = (owner >= 0 && lat == 0);
      eval();
      if (grant_o === 2'b10) bad = 1'b1;
      if (exp_ack0) m0_grants++;
      was = (owner >= 0);
      advance();
      if (!was && owner >= 0) lat = 1;
      else if (owner >= 0) lat--;
    end
    mem_ack_i = 1'b0;
    checks++;
    if (bad || m0_grants < 5)
      $display("FAIL fixed_priority: m1_granted=%b m0_done=%0d need 0 and >=5", bad, m0_grants);
    else passes++;
    en[0] = 1'b0; en[1] = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_both_same_cycle();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid_busy();
`ifdef ARB_FIXED_PRIORITY_EN
    test_fixed_priority();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
